// File: rtl/tt_lut_gate_pipe.sv
// -----------------------------------------------------------------------------
// tt_lut_gate_pipe
//
// Serially configurable 2-input logic cell for a Tiny Tapeout user slot.
// Each of CHANNELS channels looks up a 4-entry truth table with its operand
// pair {a,b} (a is the index MSB). The result is carried through PIPE_DEPTH
// register stages. Tables are loaded bit-serially into a shadow register and
// committed atomically only when exactly 4*CHANNELS bits were shifted, so the
// outputs never see a partially loaded table.
//
// Parameters
//   CHANNELS   : number of LUT channels, 1 or 2
//   PIPE_DEPTH : number of output register stages, 1..4
//
// Ports
//   io_in[0]          clk, the only clock
//   io_in[1]          rst, asynchronous active-high
//   io_in[2]          cfg_en, high while config bits are shifted in
//   io_in[3]          cfg_bit, serial config data
//   io_in[4+2c]       a operand of channel c
//   io_in[5+2c]       b operand of channel c
//   io_out[c]         pipelined LUT result of channel c
//   io_out[4]         err, last load aborted on a bad bit count
//   io_out[5]         loading, a load is in progress
//   io_out[6]         valid, pipeline holds results from the current table
//   io_out[7]         configured, at least one load committed since reset
//   remaining io_out  tied 0
// -----------------------------------------------------------------------------
module tt_lut_gate_pipe #(
    parameter int CHANNELS   = 2,
    parameter int PIPE_DEPTH = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int               W           = 4 * CHANNELS;
    localparam int               CNT_W       = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(W);
    localparam logic [W-1:0]     TABLE_RESET = {CHANNELS{4'b1100}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    logic clk;
    logic rst;
    logic cfg_en;
    logic cfg_bit;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign cfg_en  = io_in[2];
    assign cfg_bit = io_in[3];

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             shift_en;
    logic             commit;
    logic             abort;

    logic [W-1:0]     shadow_q;
    logic [W-1:0]     table_q;
    logic             err_q;
    logic             configured_q;

    logic [CHANNELS-1:0]   lut_d;
    logic [CHANNELS-1:0]   y_p [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] vld_p;

    // Truth-table lookup: entry index is {a,b}, a being the MSB.
    function automatic logic lut4(input logic [3:0] tbl, input logic a, input logic b);
        return tbl[{a, b}];
    endfunction

    // Operand pins of channels that do not exist are left unconnected.
    if (CHANNELS == 1) begin : g_one_channel
        logic unused_pins;
        assign unused_pins = ^io_in[7:6];
    end

    // ---------------------------------------------------------------------
    // Load controller: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Load controller: next state and datapath strobes. A bit beyond the
    // table width is still shifted, but it poisons the load via ovf so the
    // terminating cfg_en=0 aborts instead of committing a misaligned table.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_en) begin
                    state_d  = ST_LOAD;
                    shift_en = 1'b1;
                    cnt_d    = CNT_W'(1);
                    ovf_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cfg_en) begin
                    shift_en = 1'b1;
                    if (cnt_q < CNT_FULL) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                    if ((cnt_q == CNT_FULL) && !ovf_q) begin
                        commit = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Shadow shift register, active tables and status flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '0;
            table_q      <= TABLE_RESET;
            err_q        <= 1'b0;
            configured_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow_q <= {shadow_q[W-2:0], cfg_bit};
            end
            if (commit) begin
                table_q      <= shadow_q;
                configured_q <= 1'b1;
                err_q        <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // LUT evaluation with the active tables (combinational, stage input)
    // ---------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lut
        assign lut_d[c] = lut4(table_q[4*c +: 4], io_in[4+2*c], io_in[5+2*c]);
    end

    // ---------------------------------------------------------------------
    // Output pipeline: y_p[0] .. y_p[PIPE_DEPTH-1] with matching valid bits.
    // A commit empties the valid pipe so valid only returns once every stage
    // holds a result computed with the new table.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                y_p[i] <= '0;
            end
            vld_p <= '0;
        end else begin
            y_p[0] <= lut_d;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                y_p[i] <= y_p[i-1];
            end
            if (commit) begin
                vld_p <= '0;
            end else begin
                vld_p <= (vld_p << 1) | PIPE_DEPTH'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pad mapping
    // ---------------------------------------------------------------------
    always_comb begin
        io_out                = '0;
        io_out[CHANNELS-1:0]  = y_p[PIPE_DEPTH-1];
        io_out[4]             = err_q;
        io_out[5]             = (state_q == ST_LOAD);
        io_out[6]             = vld_p[PIPE_DEPTH-1];
        io_out[7]             = configured_q;
    end

endmodule

// File: tb/tb_tt_lut_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_tt_lut_gate_pipe
//
// Scoreboard bench. A main instance (CHANNELS=2, PIPE_DEPTH=2) receives
// scripted and random configuration loads with random operands; four
// single-channel instances (PIPE_DEPTH 1..4) share clock and reset and see
// an a0 that toggles every cycle. A reference model updated on each rising
// edge pushes the expected pad values of all five instances into a queue;
// a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_tt_lut_gate_pipe;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       cfg_en  = 1'b0;
    logic       cfg_bit = 1'b0;
    logic [3:0] pins    = 4'b0000;   // {b1, a1, b0, a0}
    logic       sa0     = 1'b0;
    logic       sb0     = 1'b0;
    logic [1:0] sjunk   = 2'b00;

    wire  [7:0] dut_in = {pins, cfg_bit, cfg_en, rst, clk};
    wire  [7:0] sw_in  = {sjunk, sb0, sa0, 2'b00, rst, clk};
    wire  [7:0] dut_out;
    wire  [7:0] sw_out [4];

    int vectors     = 0;
    int miscompares = 0;

    tt_lut_gate_pipe #(.CHANNELS(2), .PIPE_DEPTH(2)) u_dut (
        .io_in  (dut_in),
        .io_out (dut_out)
    );

    for (genvar d = 1; d <= 4; d++) begin : g_sweep
        tt_lut_gate_pipe #(.CHANNELS(1), .PIPE_DEPTH(d)) u_dut (
            .io_in  (sw_in),
            .io_out (sw_out[d-1])
        );
    end

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: what the pads must show after each rising edge.
    // ------------------------------------------------------------------
    logic [3:0]  m_tbl [2];
    logic        m_conf    = 1'b0;
    logic        m_err     = 1'b0;
    logic        m_loading = 1'b0;
    logic        cfg_bits [$];
    logic [1:0]  hist [$];        // newest LUT result first
    logic        shist [$];       // newest sweep a0 first
    int          since  = 0;      // edges since reset
    int          fill   = 0;      // edges since reset or commit
    logic [39:0] exp_q [$];

    logic [1:0]  m_res;
    logic [7:0]  m_s;
    logic [1:0]  m_y;
    logic        m_v;
    logic [7:0]  m_em;
    logic [31:0] m_es;

    always @(posedge clk) begin
        if (rst) begin
            m_tbl[0]  = 4'b1100;
            m_tbl[1]  = 4'b1100;
            m_conf    = 1'b0;
            m_err     = 1'b0;
            m_loading = 1'b0;
            cfg_bits.delete();
            hist.delete();
            shist.delete();
            since = 0;
            fill  = 0;
        end else begin
            m_res[0] = m_tbl[0][{pins[0], pins[1]}];
            m_res[1] = m_tbl[1][{pins[2], pins[3]}];
            hist.push_front(m_res);
            if (hist.size() > 4) void'(hist.pop_back());
            shist.push_front(sa0);
            if (shist.size() > 5) void'(shist.pop_back());
            if (since < 1000) since++;
            if (fill < 1000) fill++;
            if (cfg_en) begin
                if (!m_loading) begin
                    cfg_bits.delete();
                    m_loading = 1'b1;
                end
                cfg_bits.push_back(cfg_bit);
            end else if (m_loading) begin
                m_loading = 1'b0;
                if (cfg_bits.size() == 8) begin
                    for (int j = 0; j < 8; j++) m_s[7-j] = cfg_bits[j];
                    m_tbl[1] = m_s[7:4];
                    m_tbl[0] = m_s[3:0];
                    m_conf   = 1'b1;
                    m_err    = 1'b0;
                    fill     = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_y = 2'b00;
        if (since >= 2) m_y = hist[1];
        m_v  = (fill >= 2);
        m_em = {m_conf, m_v, m_loading, m_err, 2'b00, m_y};
        for (int d = 1; d <= 4; d++) begin
            m_es[8*(d-1) +: 8] = 8'h00;
            if (since >= d) m_es[8*(d-1) +: 8] = {1'b0, 1'b1, 5'b00000, shist[d-1]};
        end
        exp_q.push_back({m_es, m_em});
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [39:0] mon_e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (dut_out !== mon_e[7:0]) begin
                miscompares++;
                $display("FAIL main t=%0t io_out=%b expected %b", $time, dut_out, mon_e[7:0]);
            end
            for (int d = 0; d < 4; d++) begin
                vectors++;
                if (sw_out[d] !== mon_e[8*d+8 +: 8]) begin
                    miscompares++;
                    $display("FAIL sweep_depth%0d t=%0t io_out=%b expected %b",
                             d + 1, $time, sw_out[d], mon_e[8*d+8 +: 8]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t io_out=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic en, input logic b, input logic [3:0] p);
        cfg_en  = en;
        cfg_bit = b;
        pins    = p;
        sa0     = ~sa0;
        sb0     = 1'($urandom);
        sjunk   = 2'($urandom);
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, v[i], 4'($urandom));
        cycle(1'b0, 1'b0, 4'($urandom));
    endtask

    logic [15:0] rv;
    int          rn;
    int          ridle;

    initial begin
        // Reset defaults: a0=1 b0=0 a1=0 b1=1 -> y0=1, y1=0
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'b1001);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'b1001);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Full load: ch1 = XOR (0110), ch0 = AND (1000)
        for (int i = 7; i >= 0; i--) cycle(1'b1, rv_const(i), 4'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'b1101);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Short load
        load(16'h0015, 5);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Overflow, then a correct load
        load(16'h01a5, 9);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'($urandom));
        load(16'h0068, 8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Reset in the middle of a load
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 4'($urandom));
        #2 rst = 1'b1;
        #1;
        check_now("async_reset_main", dut_out, 8'h00);
        check_now("async_reset_sweep4", sw_out[3], 8'h00);
        cycle(1'b0, 1'b0, 4'($urandom));
        cycle(1'b0, 1'b0, 4'($urandom));
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'($urandom));
        load(16'($urandom), 8);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // cfg_en already high when reset releases
        #2 rst = 1'b1;
        rv = 16'($urandom);
        cycle(1'b1, rv[7], 4'($urandom));
        #2 rst = 1'b0;
        for (int i = 7; i >= 0; i--) cycle(1'b1, rv[i], 4'($urandom));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'($urandom));

        // Random loads of random length with random operands
        for (int k = 0; k < 30; k++) begin
            ridle = $urandom_range(0, 4);
            for (int i = 0; i < ridle; i++) cycle(1'b0, 1'b0, 4'($urandom));
            rv = 16'($urandom);
            rn = $urandom_range(1, 11);
            load(rv, rn);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'($urandom));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bits of the 0110_1000 table, MSB first.
    function automatic logic rv_const(input int i);
        logic [7:0] t;
        t = 8'b0110_1000;
        return t[i];
    endfunction

endmodule

// File: doc/tt_lut_gate_pipe.md
# tt_lut_gate_pipe

Parametrised, serially configurable 2-input logic cell for the Tiny Tapeout user-module slot. Each of CHANNELS channels applies a 4-entry truth table to its two inputs. The result is then registered through a PIPE_DEPTH-deep pipeline. Truth tables load through a bit-serial config port with length checking, and the reset-default table is y = a.

## Interface
Parameters:
- CHANNELS, default 2: number of independent LUT channels; legal values 1 and 2.
- PIPE_DEPTH, default 2: number of output register stages; legal range 1..4.

Ports (8-bit io_in / io_out pads; clock and reset are carried on io_in as in every user module):
- io_in[0]  input  1  clk; the only clock.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  cfg_en; high while config bits are being shifted in.
- io_in[3]  input  1  cfg_bit; serial config data, sampled when cfg_en=1.
- io_in[4+2c], io_in[5+2c]  input  1 each  a_c, b_c; operands of channel c. Pins are unused when CHANNELS=1.
- io_out[c]  output  1  y_c; pipelined LUT result of channel c.
- io_out[4]  output  1  err; the last load was aborted because of a bad bit count.
- io_out[5]  output  1  loading; the FSM is in LOAD.
- io_out[6]  output  1  valid; the pipeline holds results computed from the current table.
- io_out[7]  output  1  configured; at least one load has committed since reset.
- All other io_out bits are tied 0.

## Operation
- Width W = 4*CHANNELS.
- Each channel has a 4-bit active table T_c. The LUT output is T_c[{a_c,b_c}], with a as the index MSB.
- Reset value of each T_c is 4'b1100, so y = a.
- Shadow register S[W-1:0] shifts as S <= {S[W-2:0], cfg_bit}.
  - After W bits, S[4c+3:4c] becomes T_c.
  - The first bit shifted in lands in the MSB of channel CHANNELS-1.
- Bit counter cnt has range 0..W. There is also an overflow flag ovf.
- FSM states:
  - RUN (the reset state).
    - cfg_en=1: go to LOAD and shift the current cfg_bit. Set cnt=1 and ovf=0.
    - err keeps its value until the next load terminates.
  - LOAD.
    - cfg_en=1 and cnt<W: shift, cnt+1.
    - cfg_en=1 and cnt==W: shift, set ovf=1, cnt stays at W.
    - cfg_en=0 with cnt==W and ovf=0: commit. Copy S to every T_c, set configured=1, err=0, clear the valid pipe, go to RUN.
    - cfg_en=0 otherwise (short load or overflow): set err=1. T_c, configured and valid are unchanged. Go to RUN.
- The LUTs keep evaluating with the active T_c throughout LOAD. Outputs never glitch to partial tables.
- Reset values:
  - All pipeline stages 0, so every y_c is 0.
  - err=0, loading=0, configured=0.
  - valid shift register all 0.
  - S=0, cnt=0, ovf=0, state RUN.

## Timing
- Data path: LUT output is computed combinationally from io_in at edge k and shifted through PIPE_DEPTH flops, so y_c reflects edge-k inputs after edge k+PIPE_DEPTH-1.
- The valid pipe is a PIPE_DEPTH-bit shift register fed with 1 every cycle.
  - valid = MSB of that register.
  - After reset deasserts, valid rises after PIPE_DEPTH clock edges.
  - After a commit, the register is cleared and refills identically.
- Commit: the new T_c is used for inputs sampled at the edge after the cfg_en=0 edge. The first new-table result is accompanied by valid=1.
- loading is registered state: it is high from the edge that samples the first cfg_en=1 through the edge that samples cfg_en=0.
- Asynchronous reset mid-load:
  - Discards S and cnt.
  - Restores T_c to 4'b1100.
  - Clears configured and err immediately, without waiting for a clock.
- cfg_en that was already high when reset deasserts starts a load on the first edge.

## Test plan
- Reset defaults, CHANNELS=2, PIPE_DEPTH=2:
  - Stimulus: release reset; hold a0=1, b0=0, a1=0, b1=1.
  - Required: y0=1 and y1=0; valid rises at the 2nd edge; configured=0; err=0.
- Full load:
  - Stimulus: shift 8 bits 0110_1000, i.e. ch1 = XOR, ch0 = AND; then drop cfg_en.
  - Required: configured=1 and err=0. Valid drops, then returns 2 edges later. With a=b=1 on both channels: y0=1, y1=0. With a0=1, b0=0: y0=0.
- Short load:
  - Stimulus: after the full load, shift 5 bits and drop cfg_en.
  - Required: err=1, tables unchanged (AND/XOR still in force), valid stays 1.
- Overflow:
  - Stimulus: shift 9 bits.
  - Required: err=1, no commit. A following correct 8-bit load clears err.
- Reset mid-load:
  - Stimulus: assert reset after 3 bits.
  - Required: loading=0 and configured=0 immediately; y = a afterwards; a subsequent full load commits normally.
- Latency sweep:
  - Stimulus: for PIPE_DEPTH in 1..4 and CHANNELS=1, toggle a0 each cycle.
  - Required: y0 matches a0 delayed by PIPE_DEPTH edges; io_out[1], io_out[3:2] and the ch1 outputs are always 0.
